tcbm_drive_ctrl: RTL and testbench

- Drive-side TCBM handshake sequencer for the 1551-style paddle link. It services the computer's 6523 ports: PA is the byte bus, PC6 is the computer's DAV, PC7 is our ACK, and PB[1:0] carries status.
- It decodes the transfer code, moves one byte per transaction between the bus and a local byte-stream client, and drives ACK/status.
- The block sits between the paddle pins, after the synchronisers it owns, and the drive/SD firmware interface.

---
 rtl/tcbm_drive_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_tcbm_drive_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcbm_drive_ctrl.sv
// rtl/tcbm_drive_ctrl.sv - drive-side TCBM handshake sequencer for the paddle link
// DAV is synchronised and settled in one shift chain; the FSM and every output are registered.
module tcbm_drive_ctrl #(
  parameter int              SETTLE  = 2,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_dav,
  input  logic [7:0] i_pa_in,
  output logic [7:0] o_pa_out,
  output logic       o_pa_oe,
  output logic       o_ack,
  output logic [1:0] o_status,
  output logic [7:0] o_rx_data,
  output logic       o_rx_is_cmd,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  input  logic [1:0] i_tx_status,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic [1:0] i_status_in,
  output logic       o_busy,
  output logic       o_err_timeout,
  output logic       o_err_code
);

  // Two synchroniser stages, SETTLE settle stages, one stage for edge compare.
  localparam int              SYNC_LEN = SETTLE + 3;
  localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT - TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_WAIT_HI,
    S_WR_HOLD,
    S_RD_FETCH,
    S_RD_PRESENT,
    S_RD_RELEASE
  } state_t;

  state_t              r_state;
  logic [SYNC_LEN-1:0] r_dav_sh;
  logic [7:0]          r_code;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_ack;
  logic                r_pa_oe;
  logic [7:0]          r_pa_out;
  logic [1:0]          r_status;
  logic [7:0]          r_rx_data;
  logic                r_rx_is_cmd;
  logic                r_rx_valid;
  logic                r_tx_ready;
  logic                r_busy;
  logic                r_err_timeout;
  logic                r_err_code;

  state_t     w_state_nxt;
  logic [7:0] w_code_nxt;
  logic       w_ack_nxt;
  logic       w_pa_oe_nxt;
  logic [7:0] w_pa_out_nxt;
  logic [1:0] w_status_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_is_cmd_nxt;
  logic       w_rx_valid_nxt;
  logic       w_tx_ready_nxt;
  logic       w_err_timeout_nxt;
  logic       w_err_code_nxt;
  logic       w_dav_fall;
  logic       w_dav_rise;
  logic       w_code_ok;

  assign w_dav_fall = r_dav_sh[SYNC_LEN-1] & ~r_dav_sh[SYNC_LEN-2];
  assign w_dav_rise = ~r_dav_sh[SYNC_LEN-1] & r_dav_sh[SYNC_LEN-2];
  assign w_code_ok  = (i_pa_in == 8'h81) || (i_pa_in == 8'h82) ||
                      (i_pa_in == 8'h83) || (i_pa_in == 8'h84);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_dav_sh      <= '1;
      r_code        <= '0;
      r_to_cnt      <= '0;
      r_ack         <= 1'b1;
      r_pa_oe       <= 1'b0;
      r_pa_out      <= '0;
      r_status      <= '0;
      r_rx_data     <= '0;
      r_rx_is_cmd   <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_code    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dav_sh      <= {r_dav_sh[SYNC_LEN-2:0], i_dav};
      r_code        <= w_code_nxt;
      r_ack         <= w_ack_nxt;
      r_pa_oe       <= w_pa_oe_nxt;
      r_pa_out      <= w_pa_out_nxt;
      r_status      <= w_status_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_is_cmd   <= w_rx_is_cmd_nxt;
      r_rx_valid    <= w_rx_valid_nxt;
      r_tx_ready    <= w_tx_ready_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_err_timeout <= w_err_timeout_nxt;
      r_err_code    <= w_err_code_nxt;
      if (r_state == S_IDLE || w_state_nxt != r_state) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_code_nxt        = r_code;
    w_ack_nxt         = r_ack;
    w_pa_oe_nxt       = r_pa_oe;
    w_pa_out_nxt      = r_pa_out;
    w_status_nxt      = r_status;
    w_rx_data_nxt     = r_rx_data;
    w_rx_is_cmd_nxt   = r_rx_is_cmd;
    w_rx_valid_nxt    = r_rx_valid;
    w_tx_ready_nxt    = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_err_code_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_dav_fall) begin
          w_code_nxt = i_pa_in;
          if (w_code_ok) begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = S_CODE;
          end else begin
            w_err_code_nxt = 1'b1;
            w_state_nxt    = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        if (w_dav_rise) w_state_nxt = S_IDLE;
      end
      S_CODE: begin
        if (w_dav_rise) begin
          if (r_code == 8'h81 || r_code == 8'h82) begin
            w_rx_data_nxt   = i_pa_in;
            w_rx_is_cmd_nxt = (r_code == 8'h81);
            w_rx_valid_nxt  = 1'b1;
            w_state_nxt     = S_WR_HOLD;
          end else if (r_code == 8'h83) begin
            w_state_nxt = S_RD_FETCH;
          end else begin
            w_status_nxt = i_status_in;
            w_ack_nxt    = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      S_WR_HOLD: begin
        if (r_rx_valid && i_rx_ready) begin
          w_rx_valid_nxt = 1'b0;
          w_status_nxt   = i_status_in;
          w_ack_nxt      = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      S_RD_FETCH: begin
        // r_tx_ready marks the byte as taken; ack follows one clock after pa_oe.
        if (r_tx_ready) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_RD_PRESENT;
        end else if (i_tx_valid) begin
          w_tx_ready_nxt = 1'b1;
          w_pa_out_nxt   = i_tx_data;
          w_status_nxt   = i_tx_status;
          w_pa_oe_nxt    = 1'b1;
        end
      end
      S_RD_PRESENT: begin
        if (!r_pa_oe) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_RD_RELEASE;
        end else if (w_dav_fall) begin
          w_pa_oe_nxt = 1'b0;
        end
      end
      S_RD_RELEASE: begin
        if (w_dav_rise) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A real transition in the final waiting clock wins over the abort.
    if (r_state != S_IDLE && w_state_nxt == r_state && r_to_cnt == TO_LAST) begin
      w_state_nxt       = S_IDLE;
      w_pa_oe_nxt       = 1'b0;
      w_rx_valid_nxt    = 1'b0;
      w_tx_ready_nxt    = 1'b0;
      w_ack_nxt         = 1'b1;
      w_status_nxt      = 2'b00;
      w_err_timeout_nxt = 1'b1;
    end
  end

  assign o_pa_out      = r_pa_out;
  assign o_pa_oe       = r_pa_oe;
  assign o_ack         = r_ack;
  assign o_status      = r_status;
  assign o_rx_data     = r_rx_data;
  assign o_rx_is_cmd   = r_rx_is_cmd;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_ready    = r_tx_ready;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err_timeout;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_tcbm_drive_ctrl.sv
// tb/tb_tcbm_drive_ctrl.sv - self-checking bench for tcbm_drive_ctrl
// Plays the computer and the byte-stream client; expected values come from a vector table and a status model.
module tb_tcbm_drive_ctrl;

  localparam int SETTLE = 2;
  localparam int LAT    = 3 + SETTLE;
  localparam int TO     = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_dav;
  logic [7:0] i_pa_in;
  logic [7:0] o_pa_out;
  logic       o_pa_oe;
  logic       o_ack;
  logic [1:0] o_status;
  logic [7:0] o_rx_data;
  logic       o_rx_is_cmd;
  logic       o_rx_valid;
  logic       i_rx_ready;
  logic [7:0] i_tx_data;
  logic [1:0] i_tx_status;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [1:0] i_status_in;
  logic       o_busy;
  logic       o_err_timeout;
  logic       o_err_code;

  tcbm_drive_ctrl #(.SETTLE(SETTLE), .TO_W(16), .TIMEOUT(16'(TO))) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_dav        (i_dav),
    .i_pa_in      (i_pa_in),
    .o_pa_out     (o_pa_out),
    .o_pa_oe      (o_pa_oe),
    .o_ack        (o_ack),
    .o_status     (o_status),
    .o_rx_data    (o_rx_data),
    .o_rx_is_cmd  (o_rx_is_cmd),
    .o_rx_valid   (o_rx_valid),
    .i_rx_ready   (i_rx_ready),
    .i_tx_data    (i_tx_data),
    .i_tx_status  (i_tx_status),
    .i_tx_valid   (i_tx_valid),
    .o_tx_ready   (o_tx_ready),
    .i_status_in  (i_status_in),
    .o_busy       (o_busy),
    .o_err_timeout(o_err_timeout),
    .o_err_code   (o_err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] data;
    logic [1:0] st_in;
    logic [1:0] tx_st;
    int         delay;
    logic [7:0] exp_byte;
    logic       exp_cmd;
    logic [1:0] exp_status;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int w);
    case (w)
      0:       pick = o_ack;
      1:       pick = o_rx_valid;
      2:       pick = o_tx_ready;
      3:       pick = o_pa_oe;
      4:       pick = o_err_timeout;
      default: pick = o_busy;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int w, input logic val, input int limit,
                          output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (pick(w) === val) break;
    end
    n_checks++;
    if (pick(w) !== val) begin
      n_errors++;
      $display("FAIL %s: got %b after %0d clocks, expected %b", name, pick(w), limit, val);
    end
  endtask

  function automatic logic code_ok(input logic [7:0] c);
    return (c == 8'h81) || (c == 8'h82) || (c == 8'h83) || (c == 8'h84);
  endfunction

  task automatic run_txn(input vec_t v);
    int n;
    int cnt_a;
    int cnt_b;
    i_rx_ready  = 1'b0;
    i_status_in = v.st_in;
    i_pa_in     = v.code;
    i_dav       = 1'b0;
    if (code_ok(v.code)) begin
      wait_sig("ack_fall", 0, 1'b0, 20, n);
      chk("ack_fall_latency", n, LAT);
    end else begin
      cnt_a = 0;
      cnt_b = 0;
      repeat (12) begin
        @(negedge clk);
        if (o_err_code) cnt_a++;
        if (!o_ack || o_rx_valid) cnt_b++;
      end
      chk("err_code_pulses", cnt_a, 1);
      chk("bad_code_quiet", cnt_b, 0);
    end
    i_pa_in = (v.code == 8'h83) ? ~v.data : v.data;
    i_dav   = 1'b1;
    case (v.code)
      8'h81, 8'h82: begin
        wait_sig("rx_valid_rise", 1, 1'b1, 20, n);
        chk("rx_data", o_rx_data, v.exp_byte);
        chk("rx_is_cmd", o_rx_is_cmd, v.exp_cmd);
        cnt_a = 0;
        repeat (v.delay) begin
          @(negedge clk);
          if (o_ack || !o_rx_valid) cnt_a++;
        end
        chk("wr_hold_backpressure", cnt_a, 0);
        i_rx_ready = 1'b1;
        wait_sig("wr_ack_rise", 0, 1'b1, 4, n);
        chk("wr_rx_valid_clear", o_rx_valid, 1'b0);
        i_rx_ready = 1'b0;
      end
      8'h83: begin
        repeat (v.delay) @(negedge clk);
        i_tx_data   = v.data;
        i_tx_status = v.tx_st;
        i_tx_valid  = 1'b1;
        wait_sig("tx_ready", 2, 1'b1, 20, n);
        i_tx_valid = 1'b0;
        chk("rd_pa_oe_on", o_pa_oe, 1'b1);
        chk("rd_pa_out", o_pa_out, v.exp_byte);
        chk("rd_ack_before_oe_lead", o_ack, 1'b0);
        @(negedge clk);
        chk("tx_ready_single", o_tx_ready, 1'b0);
        chk("rd_ack_rise", o_ack, 1'b1);
        chk("rd_pa_oe_held", o_pa_oe, 1'b1);
        i_dav = 1'b0;
        wait_sig("rd_pa_oe_drop", 3, 1'b0, 20, n);
        chk("rd_ack_at_oe_drop", o_ack, 1'b1);
        @(negedge clk);
        chk("rd_ack_fall", o_ack, 1'b0);
        i_dav = 1'b1;
        wait_sig("rd_release_ack", 0, 1'b1, 20, n);
      end
      8'h84: wait_sig("rel_ack", 0, 1'b1, 20, n);
      default: repeat (8) @(negedge clk);
    endcase
    @(negedge clk);
    chk("idle_busy", o_busy, 1'b0);
    chk("status", o_status, v.exp_status);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       v;
    logic [1:0] model_status;
    int         n;
    int         sel;

    vecs[0] = '{8'h81, 8'h28, 2'b00, 2'b00, 0,  8'h28, 1'b1, 2'b00};
    vecs[1] = '{8'h82, 8'hA5, 2'b01, 2'b00, 50, 8'hA5, 1'b0, 2'b01};
    vecs[2] = '{8'h83, 8'h3C, 2'b00, 2'b10, 3,  8'h3C, 1'b0, 2'b10};
    vecs[3] = '{8'h55, 8'h00, 2'b11, 2'b00, 0,  8'h00, 1'b0, 2'b10};
    vecs[4] = '{8'h82, 8'h5A, 2'b11, 2'b00, 2,  8'h5A, 1'b0, 2'b11};
    vecs[5] = '{8'h84, 8'h00, 2'b01, 2'b00, 0,  8'h00, 1'b0, 2'b01};
    vecs[6] = '{8'h81, 8'hFF, 2'b10, 2'b00, 1,  8'hFF, 1'b1, 2'b10};
    vecs[7] = '{8'h83, 8'h00, 2'b01, 2'b11, 0,  8'h00, 1'b0, 2'b11};
    vecs[8] = '{8'h00, 8'h00, 2'b10, 2'b00, 0,  8'h00, 1'b0, 2'b11};

    rst         = 1'b1;
    i_dav       = 1'b1;
    i_pa_in     = 8'h00;
    i_rx_ready  = 1'b0;
    i_tx_data   = 8'h00;
    i_tx_status = 2'b00;
    i_tx_valid  = 1'b0;
    i_status_in = 2'b00;
    #1;
    chk("rst_ack", o_ack, 1'b1);
    chk("rst_pa_oe", o_pa_oe, 1'b0);
    chk("rst_pa_out", o_pa_out, 8'h00);
    chk("rst_status", o_status, 2'b00);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_tx_ready", o_tx_ready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_errs", {o_err_timeout, o_err_code}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Read with no tx byte ever offered must abort after TO clocks in RD_FETCH.
    i_pa_in = 8'h83;
    i_dav   = 1'b0;
    wait_sig("to_ack_fall", 0, 1'b0, 20, n);
    i_dav = 1'b1;
    wait_sig("timeout_pulse", 4, 1'b1, 200, n);
    chk("timeout_latency", n, LAT + TO);
    chk("to_ack", o_ack, 1'b1);
    chk("to_pa_oe", o_pa_oe, 1'b0);
    chk("to_busy", o_busy, 1'b0);
    chk("to_status", o_status, 2'b00);
    @(negedge clk);
    chk("to_pulse_single", o_err_timeout, 1'b0);
    model_status = 2'b00;

    for (int i = 0; i < 30; i++) begin
      sel          = int'($urandom_range(0, 4));
      v.data       = 8'($urandom());
      v.st_in      = 2'($urandom());
      v.tx_st      = 2'($urandom());
      v.delay      = int'($urandom_range(0, 12));
      v.exp_byte   = v.data;
      v.exp_cmd    = 1'b0;
      case (sel)
        0: v.code = 8'h81;
        1: v.code = 8'h82;
        2: v.code = 8'h83;
        3: v.code = 8'h84;
        default: begin
          v.code = 8'($urandom());
          if (code_ok(v.code)) v.code = v.code ^ 8'h10;
        end
      endcase
      if (v.code == 8'h81 || v.code == 8'h82) begin
        v.exp_cmd    = (v.code == 8'h81);
        model_status = v.st_in;
      end else if (v.code == 8'h83) begin
        model_status = v.tx_st;
      end else if (v.code == 8'h84) begin
        model_status = v.st_in;
      end
      v.exp_status = model_status;
      run_txn(v);
    end

    // Reset while the read byte is being presented.
    i_pa_in = 8'h83;
    i_dav   = 1'b0;
    wait_sig("mid_ack_fall", 0, 1'b0, 20, n);
    i_dav = 1'b1;
    i_tx_data   = 8'h77;
    i_tx_status = 2'b01;
    i_tx_valid  = 1'b1;
    wait_sig("mid_tx_ready", 2, 1'b1, 20, n);
    i_tx_valid = 1'b0;
    wait_sig("mid_present", 0, 1'b1, 5, n);
    chk("mid_pa_oe_on", o_pa_oe, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pa_oe", o_pa_oe, 1'b0);
    chk("async_ack", o_ack, 1'b1);
    chk("async_busy", o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = '{8'h84, 8'h00, 2'b11, 2'b00, 0, 8'h00, 1'b0, 2'b11};
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
